// File: rtl/inst_fetch_pkg.sv
// Shared constants and fetch-state encodings for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        Enable      = 1'b1;
  localparam logic        Disable     = 1'b0;

  typedef enum logic [1:0] {
    FetchReset = 2'd0,
    FetchIdle  = 2'd1,
    FetchRun   = 2'd2,
    FetchDrop  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {pc, inst} words with flush and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [PW-1:0] LastPtr   = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != FullCount) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rd_d = next_ptr(rd_q);
      if (do_push) wr_d = next_ptr(wr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch with prefetch buffer, single-outstanding req/ack memory port and redirect.
// Optional INST_FETCH_BYPASS_EN forwards an ack straight to decode when the buffer is empty.
//
// state      | meaning
// FetchReset | held in reset; no request, buffer empty
// FetchIdle  | one settle cycle after reset release
// FetchRun   | sequential fetching while the buffer has room
// FetchDrop  | redirect hit an outstanding request; wait for its ack and discard it
module inst_fetch import inst_fetch_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   inst_req_o,
  output logic [InstAddrBus-1:0] inst_addr_o,
  input  logic                   inst_ack_i,
  input  logic [InstBus-1:0]     inst_rdata_i,
  output logic                   inst_valid_o,
  input  logic                   inst_ready_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthCount = CW'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             pending_q, pending_d;
  logic             new_req, ack_acc, discard, keep;
  logic             fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [63:0]      fifo_head;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (branch_flag_i),
    .data_i  ({fetch_pc_q, inst_rdata_i}),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fifo_empty = (fifo_count == '0);

    // A redirect cycle never opens a new request, so nothing stale can become outstanding.
    new_req     = (state_q == FetchRun) && !pending_q && !branch_flag_i &&
                  (fifo_count < DepthCount);
    inst_req_o  = pending_q || new_req;
    inst_addr_o = pending_q ? req_addr_q : fetch_pc_q;
    ack_acc     = inst_req_o && inst_ack_i;
    discard     = branch_flag_i || (state_q == FetchDrop);
    keep        = ack_acc && !discard;
    pending_d   = inst_req_o && !inst_ack_i;
    req_addr_d  = inst_addr_o;

    case (state_q)
      FetchReset: state_d = FetchIdle;
      FetchIdle:  state_d = FetchRun;
      FetchRun:   if (branch_flag_i && pending_q && !inst_ack_i) state_d = FetchDrop;
      FetchDrop:  if (inst_ack_i) state_d = FetchRun;
      default:    state_d = FetchReset;
    endcase

    if (keep) fetch_pc_d = fetch_pc_q + 32'd4;
    if (branch_flag_i && (state_q != FetchReset)) fetch_pc_d = align_word(branch_target_i);

    inst_valid_o = !fifo_empty;
    pc_o         = fifo_empty ? ZeroWord : fifo_head[63:32];
    inst_o       = fifo_empty ? ZeroWord : fifo_head[31:0];
    fifo_push    = keep;
`ifdef INST_FETCH_BYPASS_EN
    if (fifo_empty && keep) begin
      inst_valid_o = Enable;
      pc_o         = fetch_pc_q;
      inst_o       = inst_rdata_i;
      fifo_push    = !inst_ready_i;
    end
`endif
    fifo_pop = inst_valid_o && inst_ready_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FetchReset;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      pending_q  <= Disable;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle table over the default instance plus a wrap sequence.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, br, ack, rdy;
  logic [31:0] tgt, rdata;
  logic        req, vld;
  logic [31:0] addr, pc, inst;

  logic        rst2, br2, ack2, rdy2;
  logic [31:0] tgt2, rdata2;
  logic        req2, vld2;
  logic [31:0] addr2, pc2, inst2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inst_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .branch_flag_i(br), .branch_target_i(tgt),
    .inst_req_o(req), .inst_addr_o(addr), .inst_ack_i(ack), .inst_rdata_i(rdata),
    .inst_valid_o(vld), .inst_ready_i(rdy), .pc_o(pc), .inst_o(inst)
  );

  inst_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .branch_flag_i(br2), .branch_target_i(tgt2),
    .inst_req_o(req2), .inst_addr_o(addr2), .inst_ack_i(ack2), .inst_rdata_i(rdata2),
    .inst_valid_o(vld2), .inst_ready_i(rdy2), .pc_o(pc2), .inst_o(inst2)
  );

  typedef struct {
    logic        rst, br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc, inst;
  } vec_t;

  vec_t vt[27];

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'h3400_0000 + ((a >> 2) + 32'd1) * 32'h0001_0001;
  endfunction

  function automatic vec_t mk(input logic r, input logic b, input logic [31:0] t,
                              input logic a, input logic [31:0] d, input logic y,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.br = b; v.tgt = t; v.ack = a; v.rdata = d; v.rdy = y;
    v.req = eq; v.addr = ea; v.vld = ev; v.pc = ep; v.inst = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b0; br = 1'b0; tgt = '0; ack = 1'b0; rdata = '0; rdy = 1'b1;
    rst2 = 1'b0; br2 = 1'b0; tgt2 = '0; ack2 = 1'b1; rdata2 = 32'h0000_0013; rdy2 = 1'b1;

    // rows: rst br tgt ack rdata rdy | req addr vld pc inst
    vt[0]  = mk(0,0,0,0,0,1,               0,32'h0,  0,0,0);
    vt[1]  = mk(1,0,0,0,0,1,               0,32'h0,  0,0,0);
    vt[2]  = mk(1,0,0,0,0,1,               0,32'h0,  0,0,0);
    vt[3]  = mk(1,0,0,1,32'h3401_0001,1,   1,32'h0,  0,0,0);
    vt[4]  = mk(1,0,0,1,32'h3402_0002,1,   1,32'h4,  1,32'h0,32'h3401_0001);
    vt[5]  = mk(1,0,0,1,w(32'h8),0,        1,32'h8,  1,32'h4,32'h3402_0002);
    vt[6]  = mk(1,0,0,1,w(32'hC),0,        1,32'hC,  1,32'h4,w(32'h4));
    vt[7]  = mk(1,0,0,1,w(32'h10),0,       1,32'h10, 1,32'h4,w(32'h4));
    vt[8]  = mk(1,0,0,1,32'hBAD0_0000,0,   0,32'h14, 1,32'h4,w(32'h4));
    vt[9]  = mk(1,0,0,0,0,1,               0,32'h14, 1,32'h4,w(32'h4));
    vt[10] = mk(1,0,0,0,0,1,               1,32'h14, 1,32'h8,w(32'h8));
    vt[11] = mk(1,0,0,0,0,1,               1,32'h14, 1,32'hC,w(32'hC));
    vt[12] = mk(1,1,32'h100,0,0,1,         1,32'h14, 1,32'h10,w(32'h10));
    vt[13] = mk(1,0,0,0,0,1,               1,32'h14, 0,0,0);
    vt[14] = mk(1,0,0,1,32'hDEAD_BEEF,1,   1,32'h14, 0,0,0);
    vt[15] = mk(1,0,0,1,w(32'h100),1,      1,32'h100,0,0,0);
    vt[16] = mk(1,0,0,0,0,0,               1,32'h104,1,32'h100,w(32'h100));
    vt[17] = mk(1,1,32'h203,1,32'hBAD1_1111,0, 1,32'h104,1,32'h100,w(32'h100));
    vt[18] = mk(1,0,0,1,w(32'h200),1,      1,32'h200,0,0,0);
    vt[19] = mk(1,0,0,0,0,1,               1,32'h204,1,32'h200,w(32'h200));
    vt[20] = mk(1,0,0,1,w(32'h204),0,      1,32'h204,0,0,0);
    vt[21] = mk(1,0,0,1,w(32'h208),0,      1,32'h208,1,32'h204,w(32'h204));
    vt[22] = mk(1,0,0,1,w(32'h20C),0,      1,32'h20C,1,32'h204,w(32'h204));
    vt[23] = mk(0,0,0,0,0,0,               1,32'h210,1,32'h204,w(32'h204));
    vt[24] = mk(1,0,0,0,0,1,               0,32'h0,  0,0,0);
    vt[25] = mk(1,0,0,0,0,1,               0,32'h0,  0,0,0);
    vt[26] = mk(1,0,0,0,0,1,               1,32'h0,  0,0,0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst = vt[i].rst; br = vt[i].br; tgt = vt[i].tgt;
      ack = vt[i].ack; rdata = vt[i].rdata; rdy = vt[i].rdy;
      #1;
      chk($sformatf("row%0d req", i),  {31'b0, req}, {31'b0, vt[i].req});
      chk($sformatf("row%0d addr", i), addr,         vt[i].addr);
      chk($sformatf("row%0d valid", i),{31'b0, vld}, {31'b0, vt[i].vld});
      chk($sformatf("row%0d pc", i),   pc,           vt[i].pc);
      chk($sformatf("row%0d inst", i), inst,         vt[i].inst);
    end

    // RESET_PC near the top of the address space: fetch addresses wrap to zero.
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    chk("wrap rel req",  {31'b0, req2}, 32'd0);
    chk("wrap rel addr", addr2, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("wrap idle req", {31'b0, req2}, 32'd0);
    @(negedge clk); #1;
    chk("wrap a0 req",   {31'b0, req2}, 32'd1);
    chk("wrap a0 addr",  addr2, 32'hFFFF_FFF8);
    chk("wrap a0 valid", {31'b0, vld2}, 32'd0);
    @(negedge clk); #1;
    chk("wrap a1 addr",  addr2, 32'hFFFF_FFFC);
    chk("wrap a1 pc",    pc2,   32'hFFFF_FFF8);
    chk("wrap a1 inst",  inst2, 32'h0000_0013);
    @(negedge clk); #1;
    chk("wrap a2 addr",  addr2, 32'h0000_0000);
    chk("wrap a2 pc",    pc2,   32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap a3 addr",  addr2, 32'h0000_0004);
    chk("wrap a3 pc",    pc2,   32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage with a small prefetch buffer. It drives sequential PCs to instruction memory over a req/ack handshake and buffers the returned words with their PCs. It presents them as a valid/ready stream to the decode stage's `pc_i`/`inst_i` inputs. A branch redirect flushes the buffer and any in-flight fetch, then restarts fetching at the target.

## Interface
Parameters:
- `DEPTH`, default 4: prefetch buffer entries; legal range 2..16.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on `clk`.
- `branch_flag_i`  in  1  redirect request.
- `branch_target_i`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `inst_req_o`  out  1  memory request.
- `inst_addr_o`  out  32  memory word address.
- `inst_ack_i`  in  1  memory response valid; `inst_rdata_i` is valid in the same cycle.
- `inst_rdata_i`  in  32  fetched instruction.
- `inst_valid_o`  out  1  buffer head valid toward decode.
- `inst_ready_i`  in  1  decode accepts the head (decode is not stalled).
- `pc_o`  out  32  PC of the head entry.
- `inst_o`  out  32  instruction at the head entry.

## Operation
- Buffer: a `DEPTH`-entry FIFO of {pc, inst} pairs with an occupancy `count`.
  - Push occurs on an accepted response.
  - Pop occurs when `inst_valid_o && inst_ready_i`.
  - A push and a pop in the same cycle leave `count` unchanged.
- Fetch PC register `fetch_pc`:
  - Reset value is `RESET_PC`.
  - Increments by 4 on each ack that is not discarded.
  - Wraps from 32'hFFFF_FFFC to 32'h0.
- Memory protocol:
  - At most one request is outstanding.
  - Once `inst_req_o` rises, `inst_req_o` and `inst_addr_o` stay stable until the cycle `inst_ack_i` is high.
  - `inst_ack_i` without a request is ignored.
- States:
  - RESET: active while `rst` is low. Entered on any cycle `rst` is sampled low; mid-operation reset discards all buffer contents and any pending request.
  - IDLE: one cycle after reset release; then go to FETCH.
  - FETCH:
    - `inst_req_o` = 1 when `count < DEPTH`, or when a request is already pending.
    - On ack, push {fetch_pc, inst_rdata_i}.
  - DROP:
    - Entered when `branch_flag_i` is high while a request is pending and not acked that cycle.
    - Keeps `inst_req_o` high with the old address.
    - On ack, discard the data and go to FETCH with `fetch_pc` = latched target.
- Redirect (`branch_flag_i` = 1):
  - Buffer is cleared next cycle, taking priority over push and pop that cycle.
  - Target is latched into `fetch_pc`.
  - If no request is pending, or the pending request acks in the same cycle: data discarded, stay in or enter FETCH.
  - A redirect arriving while in DROP overwrites the latched target.
- Full buffer: no new request is raised; a pending request completes because its slot was free when it was raised.
- Empty buffer: `inst_valid_o` = 0, `pc_o` = 0, `inst_o` = 0 (decodes as NOP).

## Timing
- Reset values:
  - `inst_req_o` = 0, `inst_addr_o` = `RESET_PC`.
  - `inst_valid_o` = 0, `pc_o` = 0, `inst_o` = 0, `count` = 0.
- First request is raised 2 cycles after `rst` is released (IDLE, then FETCH).
- Ack in cycle n → entry visible at `inst_valid_o` in cycle n+1.
- Sustained throughput is 1 instruction per cycle with a zero-wait memory.
- Redirect in cycle n:
  - `inst_valid_o` = 0 in cycle n+1.
  - Request to the target is raised in cycle n+1, or the cycle after the dropped ack.

## Configuration
- `INST_FETCH_BYPASS_EN`
  - Defined: when the buffer is empty and an ack arrives (not discarded), `inst_rdata_i` and `fetch_pc` drive the outputs combinationally with `inst_valid_o` = 1 in the same cycle. If `inst_ready_i` is high, the entry is not pushed.
  - Undefined: no bypass; latency is fixed at 1 cycle as stated under Timing.

## Structure
- Constants belong in `defines.v`:
  - `InstAddrBus`, `InstBus`, `ZeroWord`, `Enable`/`Disable`.
  - New fetch-state encodings: `FetchIdle`, `FetchRun`, `FetchDrop`.
- One sub-module, `fetch_fifo`: parameterised depth, width 64, push/pop/flush, count, head outputs.
- FSM, `fetch_pc` and the request logic stay in `inst_fetch`.

## Test plan
- Reset release, zero-wait ack returning 32'h3401_0001 at 0x0, 32'h3402_0002 at 0x4 → pc_o/inst_o show (0x0, 32'h3401_0001) then (0x4, 32'h3402_0002) on consecutive cycles, starting the cycle after the first ack.
- `inst_ready_i` = 0 with `DEPTH` = 4 → after 4 acks `inst_req_o` stays 0; releasing ready drains PCs 0x0, 0x4, 0x8, 0xC in order, then fetching resumes at 0x10.
- Redirect to 0x100 while request to 0x8 waits 3 cycles for ack → 0x8 data discarded, next `inst_addr_o` = 0x100, first valid head has pc_o = 0x100.
- Redirect with target 0x203 in the same cycle as an ack → ack data dropped, buffer empty next cycle, request to 0x200.
- `RESET_PC` = 32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `rst` low for one cycle while the buffer holds 3 entries → all outputs at reset values, occupancy 0, first request to `RESET_PC` 2 cycles later.
